// File: rtl/dram_burst_buffer.sv
// Line buffer between a cache-line port and a word-serial DRAM data stage.
// Optional macro BURST_CHOP_EN adds a chop input that halves the burst length.
module dram_burst_buffer #(
   parameter int WORD_W    = 32,
   parameter int BURST_LEN = 8
) (
   input  logic                        CLK,
   input  logic                        nRST,
   input  logic                        wr_req,
   input  logic                        rd_req,
`ifdef BURST_CHOP_EN
   input  logic                        chop,
`endif
   input  logic [WORD_W*BURST_LEN-1:0] line_wdata,
   output logic [WORD_W*BURST_LEN-1:0] line_rdata,
   output logic                        busy,
   output logic                        done,
   output logic                        wr_en,
   output logic                        rd_en,
   output logic                        clear,
   output logic [WORD_W-1:0]           memstore,
   input  logic [WORD_W-1:0]           memload
);

   localparam int CNT_W = $clog2(BURST_LEN);
   localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(BURST_LEN - 1);
`ifdef BURST_CHOP_EN
   localparam logic [CNT_W-1:0] LAST_CHOP = CNT_W'(BURST_LEN / 2 - 1);
`endif

   typedef enum logic [2:0] {IDLE, WRITE, READ, RDRAIN, DONE} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_next;
   logic                w_latch;
   logic                w_last;
   logic                r_cap_vld;
   logic [CNT_W-1:0]    r_cap_idx;
   logic [WORD_W-1:0]   r_wword [BURST_LEN];
   logic [WORD_W-1:0]   r_rword [BURST_LEN];
`ifdef BURST_CHOP_EN
   logic                r_chop;
   logic                w_start;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < BURST_LEN; gi++) begin : g_rline
         assign line_rdata[gi*WORD_W +: WORD_W] = r_rword[gi];
      end
   endgenerate

`ifdef BURST_CHOP_EN
   assign w_last  = (r_cnt == (r_chop ? LAST_CHOP : LAST_FULL));
   assign w_start = (r_state == IDLE) && (wr_req || rd_req);
`else
   assign w_last  = (r_cnt == LAST_FULL);
`endif

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_latch      = 1'b0;
      busy         = (r_state != IDLE);
      done         = 1'b0;
      clear        = 1'b0;
      wr_en        = 1'b0;
      rd_en        = 1'b0;
      memstore     = '0;
      case (r_state)
         IDLE: begin
            // Write wins a tie with read.
            if (wr_req) begin
               w_state_next = WRITE;
               w_cnt_next   = '0;
               w_latch      = 1'b1;
            end else if (rd_req) begin
               w_state_next = READ;
               w_cnt_next   = '0;
            end
         end
         WRITE: begin
            wr_en    = 1'b1;
            memstore = r_wword[r_cnt];
            if (w_last) begin
               w_state_next = DONE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next   = r_cnt + 1'b1;
            end
         end
         READ: begin
            rd_en = 1'b1;
            if (w_last) begin
               w_state_next = RDRAIN;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next   = r_cnt + 1'b1;
            end
         end
         RDRAIN: begin
            w_state_next = DONE;
         end
         DONE: begin
            done         = 1'b1;
            clear        = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_cap_vld <= 1'b0;
         r_cap_idx <= '0;
`ifdef BURST_CHOP_EN
         r_chop    <= 1'b0;
`endif
         for (int k = 0; k < BURST_LEN; k++) begin
            r_wword[k] <= '0;
            r_rword[k] <= '0;
         end
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         // Load data trails rd_en by one cycle, so remember which slot it belongs to.
         r_cap_vld <= rd_en;
         r_cap_idx <= r_cnt;
`ifdef BURST_CHOP_EN
         if (w_start) r_chop <= chop;
`endif
         for (int k = 0; k < BURST_LEN; k++) begin
            if (w_latch) r_wword[k] <= line_wdata[k*WORD_W +: WORD_W];
            if (r_cap_vld && (r_cap_idx == CNT_W'(k))) r_rword[k] <= memload;
         end
      end
   end

endmodule

// File: tb/tb_dram_burst_buffer.sv
// Directed bench for dram_burst_buffer: write, read, priority, mid-burst reset, chop.
module tb_dram_burst_buffer;
   localparam int W = 32;
   localparam int L = 8;

   logic           CLK = 1'b0;
   logic           nRST = 1'b1;
   logic           wr_req = 1'b0;
   logic           rd_req = 1'b0;
`ifdef BURST_CHOP_EN
   logic           chop = 1'b0;
`endif
   logic [W*L-1:0] line_wdata = '0;
   logic [W*L-1:0] line_rdata;
   logic           busy, done, wr_en, rd_en, clear;
   logic [W-1:0]   memstore;
   logic [W-1:0]   memload = '0;

   int n_pass = 0;
   int n_total = 0;

   dram_burst_buffer #(.WORD_W(W), .BURST_LEN(L)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .wr_req     (wr_req),
      .rd_req     (rd_req),
`ifdef BURST_CHOP_EN
      .chop       (chop),
`endif
      .line_wdata (line_wdata),
      .line_rdata (line_rdata),
      .busy       (busy),
      .done       (done),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .clear      (clear),
      .memstore   (memstore),
      .memload    (memload)
   );

   always #5 CLK = ~CLK;

   // Issues one read request and plays the memory side: slot k returns base+k
   // during the cycle after the k-th rd_en; any other cycle returns junk.
   task automatic run_read(input logic [W-1:0] base, input logic ch,
                           output int n_rd, output int first_rd,
                           output int last_rd, output int done_cyc);
      logic [W-1:0] pend;
      logic         pend_v;
      pend = '0; pend_v = 1'b0;
      n_rd = 0; first_rd = -1; last_rd = -1; done_cyc = -1;
      rd_req = 1'b1;
`ifdef BURST_CHOP_EN
      chop = ch;
`else
      if (ch !== 1'b0) $display("note: chop ignored in this build");
`endif
      for (int c = 0; c < 30; c++) begin
         @(negedge CLK);
         rd_req  = 1'b0;
         memload = pend_v ? pend : 32'hDEAD_BEEF;
         pend_v  = rd_en;
         if (rd_en) begin
            pend = base + W'(n_rd);
            if (first_rd < 0) first_rd = c;
            last_rd = c;
            n_rd++;
         end
         if (done) begin
            done_cyc = c;
            break;
         end
      end
`ifdef BURST_CHOP_EN
      chop = 1'b0;
`endif
      @(negedge CLK);
   endtask

   task automatic test_reset();
      nRST = 1'b1;
      #2 nRST = 1'b0;
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0h exp=0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%0h exp=0", done); else n_pass++;
      n_total++; if ({wr_en, rd_en, clear} !== 3'b000) $display("FAIL reset_en got=%b exp=000", {wr_en, rd_en, clear}); else n_pass++;
      n_total++; if (memstore !== '0) $display("FAIL reset_memstore got=%0h exp=0", memstore); else n_pass++;
      n_total++; if (line_rdata !== '0) $display("FAIL reset_rdata got=%0h exp=0", line_rdata); else n_pass++;
      @(negedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      @(negedge CLK);
      n_total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got=%0h exp=0", busy); else n_pass++;
   endtask

   task automatic test_write();
      for (int k = 0; k < L; k++) line_wdata[k*W +: W] = 32'h11 * (k + 1);
      wr_req = 1'b1;
      @(negedge CLK);
      wr_req = 1'b0;
      for (int k = 0; k < L; k++) begin
         n_total++; if (wr_en !== 1'b1 || rd_en !== 1'b0) $display("FAIL write_en[%0d] wr=%b rd=%b exp wr=1 rd=0", k, wr_en, rd_en); else n_pass++;
         n_total++; if (memstore !== 32'h11 * (k + 1)) $display("FAIL write_data[%0d] got=%0h exp=%0h", k, memstore, 32'h11 * (k + 1)); else n_pass++;
         @(negedge CLK);
      end
      n_total++; if ({done, clear, wr_en, busy} !== 4'b1101) $display("FAIL write_done done,clear,wr_en,busy got=%b exp=1101", {done, clear, wr_en, busy}); else n_pass++;
      n_total++; if (memstore !== '0) $display("FAIL write_memstore_idle got=%0h exp=0", memstore); else n_pass++;
      @(negedge CLK);
      n_total++; if ({done, clear, busy} !== 3'b000) $display("FAIL write_after done,clear,busy got=%b exp=000", {done, clear, busy}); else n_pass++;
   endtask

   task automatic test_priority();
      bit seen;
      for (int k = 0; k < L; k++) line_wdata[k*W +: W] = 32'h100 + k;
      wr_req = 1'b1;
      rd_req = 1'b1;
      @(negedge CLK);
      wr_req = 1'b0;
      for (int k = 0; k < L; k++) begin
         n_total++; if (wr_en !== 1'b1 || rd_en !== 1'b0) $display("FAIL prio_en[%0d] wr=%b rd=%b exp wr=1 rd=0", k, wr_en, rd_en); else n_pass++;
         n_total++; if (memstore !== 32'h100 + k) $display("FAIL prio_data[%0d] got=%0h exp=%0h", k, memstore, 32'h100 + k); else n_pass++;
         @(negedge CLK);
      end
      n_total++; if ({done, rd_en} !== 2'b10) $display("FAIL prio_done done,rd_en got=%b exp=10", {done, rd_en}); else n_pass++;
      @(negedge CLK);
      n_total++; if ({busy, rd_en} !== 2'b00) $display("FAIL prio_idle busy,rd_en got=%b exp=00", {busy, rd_en}); else n_pass++;
      @(negedge CLK);
      n_total++; if (rd_en !== 1'b1) $display("FAIL prio_read_start got=%b exp=1", rd_en); else n_pass++;
      rd_req = 1'b0;
      memload = 32'h55;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      n_total++; if (seen !== 1'b1) $display("FAIL prio_read_done got=%b exp=1", seen); else n_pass++;
      @(negedge CLK);
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < L; k++) line_wdata[k*W +: W] = 32'h200 + k;
      wr_req = 1'b1;
      @(negedge CLK);
      wr_req = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      n_total++; if (memstore !== 32'h202) $display("FAIL midrst_pre got=%0h exp=202", memstore); else n_pass++;
      nRST = 1'b0;
      #1;
      n_total++; if ({busy, done, wr_en, rd_en, clear} !== 5'b0) $display("FAIL midrst_ctl got=%b exp=00000", {busy, done, wr_en, rd_en, clear}); else n_pass++;
      n_total++; if (memstore !== '0) $display("FAIL midrst_memstore got=%0h exp=0", memstore); else n_pass++;
      n_total++; if (line_rdata !== '0) $display("FAIL midrst_rdata got=%0h exp=0", line_rdata); else n_pass++;
      @(negedge CLK);
      nRST = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         n_total++; if ({busy, done} !== 2'b00) $display("FAIL midrst_quiet[%0d] busy,done got=%b exp=00", c, {busy, done}); else n_pass++;
      end
      wr_req = 1'b1;
      @(negedge CLK);
      wr_req = 1'b0;
      for (int k = 0; k < L; k++) begin
         n_total++; if (wr_en !== 1'b1 || memstore !== 32'h200 + k) $display("FAIL midrst_burst[%0d] wr=%b data=%0h exp wr=1 data=%0h", k, wr_en, memstore, 32'h200 + k); else n_pass++;
         @(negedge CLK);
      end
      n_total++; if (done !== 1'b1) $display("FAIL midrst_done got=%b exp=1", done); else n_pass++;
      @(negedge CLK);
   endtask

   task automatic test_read();
      int n_rd, first_rd, last_rd, done_cyc;
      run_read(32'hA0, 1'b0, n_rd, first_rd, last_rd, done_cyc);
      n_total++; if (n_rd !== 8) $display("FAIL read_count got=%0d exp=8", n_rd); else n_pass++;
      n_total++; if (last_rd - first_rd !== 7) $display("FAIL read_contig got=%0d exp=7", last_rd - first_rd); else n_pass++;
      n_total++; if (done_cyc - last_rd !== 2) $display("FAIL read_done_lat got=%0d exp=2", done_cyc - last_rd); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL read_idle got=%b exp=0", busy); else n_pass++;
      for (int k = 0; k < L; k++) begin
         n_total++; if (line_rdata[k*W +: W] !== 32'hA0 + k) $display("FAIL read_word[%0d] got=%0h exp=%0h", k, line_rdata[k*W +: W], 32'hA0 + k); else n_pass++;
      end
   endtask

`ifdef BURST_CHOP_EN
   task automatic test_chop();
      int n_rd, first_rd, last_rd, done_cyc;
      logic [W-1:0] exp_w;
      run_read(32'hB0, 1'b1, n_rd, first_rd, last_rd, done_cyc);
      n_total++; if (n_rd !== 4) $display("FAIL chop_count got=%0d exp=4", n_rd); else n_pass++;
      n_total++; if (done_cyc - last_rd !== 2) $display("FAIL chop_done_lat got=%0d exp=2", done_cyc - last_rd); else n_pass++;
      for (int k = 0; k < L; k++) begin
         exp_w = (k < 4) ? 32'hB0 + k : 32'hA0 + k;
         n_total++; if (line_rdata[k*W +: W] !== exp_w) $display("FAIL chop_word[%0d] got=%0h exp=%0h", k, line_rdata[k*W +: W], exp_w); else n_pass++;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_priority();
      test_reset_mid();
      test_read();
`ifdef BURST_CHOP_EN
      test_chop();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
